axil_timer: RTL and testbench

AXI-Lite timer peripheral: a 64-bit free-running/compare timer with programmable prescaler and a level interrupt output. It sits downstream of the Z-Core AXI-Lite interconnect as slave M3 at base 0x0400_2000 with a 4 KB window (12-bit local address). It consumes the interconnect's master-port transactions and gives software a time base and a periodic or one-shot interrupt source.

---
 rtl/z_core_timer_pkg.sv | 44 ++++
 rtl/axil_timer_core.sv | 103 ++++++++++
 rtl/axil_timer.sv | 190 +++++++++++++++++++
 tb/tb_axil_timer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_core_timer_pkg.sv
// Shared constants and types for the AXI-Lite timer: register offsets, bit
// indices, response codes and the two bus-side FSM encodings.
package z_core_timer_pkg;

    localparam logic [11:0] OFF_CTRL     = 12'h000;
    localparam logic [11:0] OFF_PRESCALE = 12'h004;
    localparam logic [11:0] OFF_COUNT_LO = 12'h008;
    localparam logic [11:0] OFF_COUNT_HI = 12'h00C;
    localparam logic [11:0] OFF_CMP_LO   = 12'h010;
    localparam logic [11:0] OFF_CMP_HI   = 12'h014;
    localparam logic [11:0] OFF_STATUS   = 12'h018;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_MATCH     = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_timer_core.sv
// Timer datapath: prescaler, 64-bit counter with compare, MATCH/irq and the
// COUNT_HI shadow used to make 64-bit reads atomic.
module axil_timer_core
    import z_core_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [31:0]                 wr_data,
    input  logic                        ctrl_we,
    input  logic [PRESCALE_WIDTH/8-1:0] psc_we,
    input  logic [3:0]                  cnt_lo_we,
    input  logic [3:0]                  cnt_hi_we,
    input  logic [3:0]                  cmp_lo_we,
    input  logic [3:0]                  cmp_hi_we,
    input  logic                        status_clr,
    input  logic                        latch_shadow,
    output logic [2:0]                  ctrl,
    output logic [PRESCALE_WIDTH-1:0]   prescale,
    output logic [31:0]                 count_lo,
    output logic [63:0]                 cmp,
    output logic                        match,
    output logic [31:0]                 shadow_hi,
    output logic                        irq
);

    logic [2:0]                ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [63:0]               count_q, count_d;
    logic [63:0]               cmp_q, cmp_d;
    logic                      match_q, match_d;
    logic [31:0]               shadow_q, shadow_d;
    logic                      irq_q, irq_d;
    logic                      tick;
    logic                      hit;

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;
        count_d    = count_q;
        match_d    = match_q;
        shadow_d   = shadow_q;
        tick       = ctrl_q[CTRL_EN] && (psc_cnt_q == prescale_q);
        hit        = tick && (count_q == cmp_q);

        if (ctrl_q[CTRL_EN]) psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
        if (tick) count_d = (hit && ctrl_q[CTRL_AUTO_RELOAD]) ? 64'd0 : count_q + 64'd1;
        // A software write to either COUNT half replaces this cycle's tick update.
        if ((cnt_lo_we != 4'd0) || (cnt_hi_we != 4'd0)) begin
            count_d = {apply_strb(count_q[63:32], wr_data, cnt_hi_we),
                       apply_strb(count_q[31:0],  wr_data, cnt_lo_we)};
        end
        cmp_d = {apply_strb(cmp_q[63:32], wr_data, cmp_hi_we),
                 apply_strb(cmp_q[31:0],  wr_data, cmp_lo_we)};

        if (ctrl_we) ctrl_d = wr_data[2:0];
        for (int i = 0; i < PRESCALE_WIDTH/8; i++) begin
            if (psc_we[i]) prescale_d[i*8 +: 8] = wr_data[i*8 +: 8];
        end
        if (psc_we != '0) psc_cnt_d = '0;

        // Set is applied after clear so a coincident match survives the W1C.
        if (status_clr) match_d = 1'b0;
        if (hit) match_d = 1'b1;

        if (latch_shadow) shadow_d = count_q[63:32];
        irq_d = match_q & ctrl_q[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            psc_cnt_q  <= '0;
            count_q    <= '0;
            cmp_q      <= '1;
            match_q    <= 1'b0;
            shadow_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            shadow_q   <= shadow_d;
            irq_q      <= irq_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign prescale  = prescale_q;
    assign count_lo  = count_q[31:0];
    assign cmp       = cmp_q;
    assign match     = match_q;
    assign shadow_hi = shadow_q;
    assign irq       = irq_q;

endmodule

// File: rtl/axil_timer.sv
// AXI-Lite front end of the timer: independent write and read FSMs plus the
// register decode feeding axil_timer_core.
module axil_timer
    import z_core_timer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  irq
);

    // Handshakes: a channel transfers on a clock edge where valid and ready are
    // both high; AW and W are only accepted together, in the cycle after both are seen.
    wr_state_e wstate_q, wstate_d;
    rd_state_e rstate_q, rstate_d;
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0]     waddr, raddr;
    logic                      wr_go;
    logic [DATA_WIDTH-1:0]     rd_val;
    logic                      rd_ok;
    logic [2:0]                ctrl;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [31:0]               count_lo;
    logic [63:0]               cmp;
    logic                      match;
    logic [31:0]               shadow_hi;
    logic                      unused_inputs;

    assign waddr = {s_axil_awaddr[ADDR_WIDTH-1:2], 2'b00};
    assign raddr = {s_axil_araddr[ADDR_WIDTH-1:2], 2'b00};
    assign wr_go = (wstate_q == W_ACK);
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                             s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (wstate_q)
            W_IDLE: if (s_axil_awvalid && s_axil_wvalid) begin
                wstate_d  = W_ACK;
                awready_d = 1'b1;
            end
            W_ACK: begin
                wstate_d = W_RESP;
                bvalid_d = 1'b1;
                bresp_d  = (waddr <= OFF_STATUS) ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: if (s_axil_bready) begin
                wstate_d = W_IDLE;
                bvalid_d = 1'b0;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (raddr)
            OFF_CTRL:     rd_val = {{(DATA_WIDTH-3){1'b0}}, ctrl};
            OFF_PRESCALE: rd_val = {{(DATA_WIDTH-PRESCALE_WIDTH){1'b0}}, prescale};
            OFF_COUNT_LO: rd_val = count_lo;
            OFF_COUNT_HI: rd_val = shadow_hi;
            OFF_CMP_LO:   rd_val = cmp[31:0];
            OFF_CMP_HI:   rd_val = cmp[63:32];
            OFF_STATUS:   rd_val = {{(DATA_WIDTH-1){1'b0}}, match};
            default:      rd_ok  = 1'b0;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            R_IDLE: if (s_axil_arvalid) begin
                rstate_d  = R_ACK;
                arready_d = 1'b1;
            end
            R_ACK: begin
                rstate_d = R_DATA;
                rvalid_d = 1'b1;
                rdata_d  = rd_val;
                rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            R_DATA: if (s_axil_rready) begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    axil_timer_core #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_core (
        .clk         (clk),
        .rstn        (rstn),
        .wr_data     (s_axil_wdata),
        .ctrl_we     (wr_go && (waddr == OFF_CTRL) && s_axil_wstrb[0]),
        .psc_we      ((wr_go && (waddr == OFF_PRESCALE)) ? s_axil_wstrb[PRESCALE_WIDTH/8-1:0] : '0),
        .cnt_lo_we   ((wr_go && (waddr == OFF_COUNT_LO)) ? s_axil_wstrb : '0),
        .cnt_hi_we   ((wr_go && (waddr == OFF_COUNT_HI)) ? s_axil_wstrb : '0),
        .cmp_lo_we   ((wr_go && (waddr == OFF_CMP_LO)) ? s_axil_wstrb : '0),
        .cmp_hi_we   ((wr_go && (waddr == OFF_CMP_HI)) ? s_axil_wstrb : '0),
        .status_clr  (wr_go && (waddr == OFF_STATUS) && s_axil_wstrb[0] && s_axil_wdata[STATUS_MATCH]),
        .latch_shadow((rstate_q == R_ACK) && (raddr == OFF_COUNT_LO)),
        .ctrl        (ctrl),
        .prescale    (prescale),
        .count_lo    (count_lo),
        .cmp         (cmp),
        .match       (match),
        .shadow_hi   (shadow_hi),
        .irq         (irq)
    );

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = awready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_timer.sv
// Bench for axil_timer: randomized AXI-Lite traffic against a per-cycle
// reference of the timer registers, with queued expected responses.
module tb_axil_timer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [11:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [33:0] rd_exp_q[$];
    logic [1:0]  wr_exp_q[$];

    // reference state of the timer
    longint unsigned m_cnt, m_cmp, n_cnt, n_cmp;
    int unsigned     m_psc, m_prescale, n_psc, n_prescale;
    bit              m_en, m_ar, m_ie, m_match, m_irq, n_en, n_ar, n_ie, n_match;
    logic [31:0]     m_shadow, n_shadow;
    bit              m_tick, m_set;

    axil_timer dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout or unexpected event at %0t", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_psc = 0; m_prescale = 0;
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_irq = 0; m_shadow = '0;
    endtask

    function automatic logic [33:0] model_read(input logic [11:0] a);
        logic [9:0] w;
        w = a[11:2];
        case (w)
            10'd0:   return {2'b00, 29'd0, m_ie, m_ar, m_en};
            10'd1:   return {2'b00, 16'd0, m_prescale[15:0]};
            10'd2:   return {2'b00, m_cnt[31:0]};
            10'd3:   return {2'b00, m_shadow};
            10'd4:   return {2'b00, m_cmp[31:0]};
            10'd5:   return {2'b00, m_cmp[63:32]};
            10'd6:   return {2'b00, 31'd0, m_match};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    // Reference timer: at each falling edge work out what the next rising edge does.
    always @(negedge clk) begin
        if (!rstn) begin
            model_reset();
        end else begin
            chk("irq", irq, m_irq);
            n_cnt = m_cnt; n_cmp = m_cmp; n_psc = m_psc; n_prescale = m_prescale;
            n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_match = m_match; n_shadow = m_shadow;
            if (arvalid && arready) begin
                rd_exp_q.push_back(model_read(araddr));
                if (araddr[11:2] == 10'd2) n_shadow = m_cnt[63:32];
            end
            m_tick = m_en && (m_psc == m_prescale);
            m_set  = m_tick && (m_cnt == m_cmp);
            if (m_en) n_psc = m_tick ? 0 : m_psc + 1;
            if (m_tick) n_cnt = (m_set && m_ar) ? 64'd0 : m_cnt + 64'd1;
            if (awvalid && wvalid && awready && wready) begin
                wr_exp_q.push_back((awaddr[11:2] <= 10'd6) ? 2'b00 : 2'b10);
                case (awaddr[11:2])
                    10'd0: if (wstrb[0]) {n_ie, n_ar, n_en} = wdata[2:0];
                    10'd1: begin
                        n_prescale = merge(m_prescale, wdata, {2'b00, wstrb[1:0]});
                        n_psc = 0;
                    end
                    10'd2: if (wstrb != 0) n_cnt = {m_cnt[63:32], merge(m_cnt[31:0], wdata, wstrb)};
                    10'd3: if (wstrb != 0) n_cnt = {merge(m_cnt[63:32], wdata, wstrb), m_cnt[31:0]};
                    10'd4: n_cmp = {m_cmp[63:32], merge(m_cmp[31:0], wdata, wstrb)};
                    10'd5: n_cmp = {merge(m_cmp[63:32], wdata, wstrb), m_cmp[31:0]};
                    10'd6: if (wstrb[0] && wdata[0]) n_match = 0;
                    default: ;
                endcase
            end
            if (m_set) n_match = 1;
            m_irq = m_match && m_ie;
            m_cnt = n_cnt; m_cmp = n_cmp; m_psc = n_psc; m_prescale = n_prescale;
            m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_match = n_match; m_shadow = n_shadow;
        end
    end

    // Monitor: pops an expected response whenever a response handshake completes.
    always @(negedge clk) begin
        logic [33:0] re;
        logic [1:0]  we;
        if (rstn) begin
            if (rvalid && rready) begin
                if (rd_exp_q.size() == 0) fail("rd_unexpected");
                else begin
                    re = rd_exp_q.pop_front();
                    chk("rdata", rdata, re[31:0]);
                    chk("rresp", rresp, re[33:32]);
                end
            end
            if (bvalid && bready) begin
                if (wr_exp_q.size() == 0) fail("wr_unexpected");
                else begin
                    we = wr_exp_q.pop_front();
                    chk("bresp", bresp, we);
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit wait_b);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 50);
        if (!(awready && wready)) fail("aw_handshake");
        else chk("aw_latency", n, 2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (wait_b) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 50);
            if (!(bvalid && bready)) fail("b_handshake");
            else chk("b_latency", n, 1);
            @(posedge clk);
        end
    endtask

    task automatic axi_read(input logic [11:0] a, input bit wait_r, output logic [31:0] d);
        int n;
        d = '0;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) fail("ar_handshake");
        else chk("ar_latency", n, 2);
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (wait_r) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 50);
            if (!(rvalid && rready)) fail("r_handshake");
            else begin
                chk("r_latency", n, 1);
                d = rdata;
            end
            @(posedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [11:0] a;
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) axi_read(12'(i * 4), 1, d);

        // Prescaler: one count per 4 clocks.
        axi_write(12'h004, 32'd3, 4'hF, 1);
        axi_write(12'h008, 32'd0, 4'hF, 1);
        axi_write(12'h000, 32'd1, 4'h1, 1);
        repeat (40) @(posedge clk);
        axi_read(12'h008, 1, d);
        total++;
        if (d < 9 || d > 11) begin
            bad++;
            $display("FAIL psc_count: got %0d expected 10+-1", d);
        end

        // Low-word carry between the LO and HI reads.
        for (int i = 0; i < 6; i++) begin
            axi_write(12'h000, 32'd0, 4'hF, 1);
            axi_write(12'h004, 32'd0, 4'hF, 1);
            axi_write(12'h00C, 32'($urandom_range(0, 3)), 4'hF, 1);
            axi_write(12'h008, 32'hFFFF_FFFF - 32'($urandom_range(0, 12)), 4'hF, 1);
            axi_write(12'h000, 32'd1, 4'h1, 1);
            axi_read(12'h008, 1, d);
            axi_read(12'h00C, 1, d);
        end

        // Compare with auto-reload and interrupt.
        axi_write(12'h000, 32'd0, 4'hF, 1);
        axi_write(12'h008, 32'd0, 4'hF, 1);
        axi_write(12'h00C, 32'd0, 4'hF, 1);
        axi_write(12'h014, 32'd0, 4'hF, 1);
        axi_write(12'h010, 32'd5, 4'hF, 1);
        axi_write(12'h000, 32'd7, 4'h1, 1);
        for (int i = 0; i < 8; i++) axi_read(12'h008, 1, d);
        for (int i = 0; i < 18; i++) begin
            repeat (i % 6) @(posedge clk);
            axi_write(12'h018, 32'd1, 4'h1, 1);
            axi_read(12'h018, 1, d);
        end

        // Unmapped offsets and AW ahead of W.
        axi_write(12'h01C, $urandom, 4'hF, 1);
        axi_read(12'h100, 1, d);
        for (int i = 0; i < 7; i++) axi_read(12'(i * 4), 1, d);
        @(posedge clk); #1;
        awaddr = 12'h010; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1;
        repeat (3) begin @(negedge clk); chk("aw_waits_for_w", awready, 0); end
        @(posedge clk); #1;
        wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 50);
        if (!(awready && wready)) fail("aw_late_w");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 50);
        @(posedge clk);

        // Random traffic, including same-edge read/write pairs.
        for (int i = 0; i < 60; i++) begin
            a = 12'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: axi_write(a, $urandom, 4'($urandom_range(1, 15)), 1);
                1: axi_read(a, 1, d);
                default: fork
                    axi_write(a, $urandom, 4'($urandom_range(1, 15)), 1);
                    axi_read(a, 1, d);
                join
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Stalled responses, then reset while they are pending.
        bready = 1'b0;
        rready = 1'b0;
        axi_write(12'h000, 32'd5, 4'h1, 0);
        axi_read(12'h010, 0, d);
        repeat (10) begin
            @(negedge clk);
            chk("stall_bvalid", bvalid, 1);
            chk("stall_rvalid", rvalid, 1);
            if (rd_exp_q.size() > 0) chk("stall_rdata", rdata, rd_exp_q[0][31:0]);
            if (wr_exp_q.size() > 0) chk("stall_bresp", bresp, wr_exp_q[0]);
        end
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("async_bvalid", bvalid, 0);
        chk("async_rvalid", rvalid, 0);
        rd_exp_q.delete();
        wr_exp_q.delete();
        bready = 1'b1;
        rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 7; i++) axi_read(12'(i * 4), 1, d);

        repeat (3) @(posedge clk);
        chk("rd_q_empty", rd_exp_q.size(), 0);
        chk("wr_q_empty", wr_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
